// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator datapath control.
// Sequencer state encoding, ALU operation encodings shared with the decoder
// and ALU, and the post-reset ALU operation.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } calc_state_t;

    localparam logic [3:0] ALU_OP_PASS = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0001;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0010;
    localparam logic [3:0] ALU_OP_AND  = 4'b0011;
    localparam logic [3:0] ALU_OP_OR   = 4'b0100;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0101;
    localparam logic [3:0] ALU_OP_SHL  = 4'b0110;
    localparam logic [3:0] ALU_OP_SHR  = 4'b0111;

    localparam logic [3:0] ALU_OP_RST  = 4'b0000;

    // Final lat_cnt value inside EXEC for a given ALU latency (0 never enters EXEC).
    function automatic logic [3:0] lat_last(input int unsigned alu_lat);
        return (alu_lat == 0) ? 4'd0 : 4'(alu_lat - 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser followed by an optional conditioner.
// CALC_DEBOUNCE_EN defined  : clean follows the synchronised level only after
//                             it has differed for DB_CYCLES consecutive cycles.
// CALC_DEBOUNCE_EN undefined: clean is the synchroniser output (DB_CYCLES unused).
module btn_debounce
    import calc_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic btnu,
    input  logic raw,
    output logic clean
);

    if (DB_CYCLES == 0) begin : g_bad_db_cycles
        $error("btn_debounce: DB_CYCLES must be at least 1");
    end

    logic sync1;
    logic sync2;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or posedge btnu) begin
        if (btnu) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_ff @(posedge clk or posedge btnu) begin
        if (btnu) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (sync2 == clean) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            clean <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign clean = sync2;
`endif

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: operation sequencer for the calculator.
// Conditions the select and execute buttons, latches the decoder's alu_op on
// each accepted btnd press, waits out the ALU latency and issues exactly one
// accumulator write per press. Debounce is enabled by defining CALC_DEBOUNCE_EN.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             btnu,
    input  logic             btnl,
    input  logic             btnc,
    input  logic             btnr,
    input  logic             btnd,
    input  logic [3:0]       alu_op_in,
    output logic             sel_l,
    output logic             sel_c,
    output logic             sel_r,
    output logic [3:0]       alu_op,
    output logic             acc_en,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    if (ALU_LAT > 15) begin : g_bad_alu_lat
        $error("calc_ctrl: ALU_LAT must be in 0..15");
    end

    localparam logic [3:0] LAT_LAST = lat_last(ALU_LAT);

    logic        exe_clean;
    logic        exe_prev;
    logic        exe_rise;
    calc_state_t state;
    logic [3:0]  lat_cnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (
        .clk(clk), .btnu(btnu), .raw(btnl), .clean(sel_l)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (
        .clk(clk), .btnu(btnu), .raw(btnc), .clean(sel_c)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk(clk), .btnu(btnu), .raw(btnr), .clean(sel_r)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_d (
        .clk(clk), .btnu(btnu), .raw(btnd), .clean(exe_clean)
    );

    // Previous clean execute level for rising-edge detection.
    always_ff @(posedge clk or posedge btnu) begin
        if (btnu) begin
            exe_prev <= 1'b0;
        end else begin
            exe_prev <= exe_clean;
        end
    end

    assign exe_rise = exe_clean & ~exe_prev;

    // Sequencer: latch op, wait ALU latency, one write, then wait for release.
    always_ff @(posedge clk or posedge btnu) begin
        if (btnu) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            alu_op   <= ALU_OP_RST;
            acc_en   <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
        end else begin
            acc_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (exe_rise) begin
                        alu_op  <= alu_op_in;
                        lat_cnt <= '0;
                        busy    <= 1'b1;
                        if (ALU_LAT == 0) begin
                            state  <= WRITE;
                            acc_en <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (lat_cnt == LAT_LAST) begin
                        state  <= WRITE;
                        acc_en <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                WRITE: begin
                    op_count <= op_count + CNT_W'(1);
                    state    <= HOLD;
                end
                HOLD: begin
                    if (!exe_clean) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: scoreboard bench for calc_ctrl (DB_CYCLES=4, ALU_LAT=2, CNT_W=8).
// Expectations follow CALC_DEBOUNCE_EN as defined for the compilation.
module tb_calc_ctrl;

    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 8;

    logic          clk = 1'b0;
    logic          btnu, btnl, btnc, btnr, btnd;
    logic [3:0]    alu_op_in;
    logic          sel_l, sel_c, sel_r;
    logic [3:0]    alu_op;
    logic          acc_en, busy;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    calc_ctrl #(.DB_CYCLES(DB), .ALU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .btnu(btnu), .btnl(btnl), .btnc(btnc), .btnr(btnr),
        .btnd(btnd), .alu_op_in(alu_op_in), .sel_l(sel_l), .sel_c(sel_c),
        .sel_r(sel_r), .alu_op(alu_op), .acc_en(acc_en), .busy(busy),
        .op_count(op_count)
    );

    typedef struct {
        int unsigned   edge_no;
        logic [3:0]    op;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned acc_seen = 0;
    bit          busy_seen = 1'b0;

    // Reference model: button levels as seen after synchronising/conditioning,
    // and the press-to-write schedule derived from them.
    bit          m_s1[4], m_s2[4], m_clean[4];
    bit [DB-1:0] m_hist[4];
    bit          m_exe_prev;
    bit          m_busy, exp_busy, pending, release_pend;
    int unsigned hold_from;
    int unsigned m_writes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int b = 0; b < 4; b++) begin
            m_s1[b]    = 1'b0;
            m_s2[b]    = 1'b0;
            m_clean[b] = 1'b0;
            m_hist[b]  = '0;
        end
        m_exe_prev   = 1'b0;
        m_busy       = 1'b0;
        exp_busy     = 1'b0;
        pending      = 1'b0;
        release_pend = 1'b0;
        hold_from    = '1;
        m_writes     = 0;
        q.delete();
    endfunction

    always @(posedge clk) begin : model
        bit raw[4];
        bit s2_old;
        bit rise;
        cyc++;
        if (btnu) begin
            model_clear();
        end else begin
            raw[0] = btnl; raw[1] = btnc; raw[2] = btnr; raw[3] = btnd;
            for (int b = 0; b < 4; b++) begin
                s2_old  = m_s2[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
`ifdef CALC_DEBOUNCE_EN
                m_hist[b] = {m_hist[b][DB-2:0], s2_old};
                if (m_hist[b] == {DB{~m_clean[b]}}) m_clean[b] = ~m_clean[b];
`else
                m_clean[b] = m_s2[b];
`endif
            end
            rise       = m_clean[3] && !m_exe_prev;
            m_exe_prev = m_clean[3];
            if (release_pend) begin
                m_busy       = 1'b0;
                exp_busy     = 1'b0;
                release_pend = 1'b0;
                hold_from    = '1;
            end
            if (pending) begin
                q.push_back('{cyc + LAT, alu_op_in, CW'(m_writes)});
                m_writes++;
                hold_from = cyc + LAT + 1;
                exp_busy  = 1'b1;
                pending   = 1'b0;
            end else if (m_busy && cyc >= hold_from && !m_clean[3]) begin
                release_pend = 1'b1;
            end
            if (!m_busy && rise) begin
                pending = 1'b1;
                m_busy  = 1'b1;
            end
        end
    end

    // Monitor: per-cycle level checks plus scoreboard pop on every write.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!btnu) begin
            check("sel_l", sel_l, m_clean[0]);
            check("sel_c", sel_c, m_clean[1]);
            check("sel_r", sel_r, m_clean[2]);
            check("busy", busy, exp_busy);
            if (busy) busy_seen = 1'b1;
            if (acc_en) begin
                acc_seen++;
                if (q.size() == 0) begin
                    check("acc_en_unexpected", acc_en, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("acc_en_cycle", cyc, e.edge_no);
                    check("alu_op_at_write", alu_op, e.op);
                    check("op_count_at_write", op_count, e.cnt);
                end
            end else if (q.size() > 0 && q[0].edge_no < cyc) begin
                e = q.pop_front();
                check("acc_en_missing", acc_en, 1'b1);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (busy) seen = 1'b1;
        end
        if (!seen) check(name, busy, 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        btnu = 1'b1;
        btnd = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_acc_en", acc_en, 1'b0);
        check("rst_op_count", op_count, '0);
        check("rst_alu_op", alu_op, 4'b0000);
        model_clear();
        #1;
        btnu = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned a0;
        btnu = 1'b1; btnl = 1'b0; btnc = 1'b0; btnr = 1'b0; btnd = 1'b0;
        alu_op_in = 4'b0000;
        tick(2);
        check("init_busy", busy, 1'b0);
        check("init_acc_en", acc_en, 1'b0);
        check("init_op_count", op_count, '0);
        check("init_alu_op", alu_op, 4'b0000);
        check("init_sel", {sel_l, sel_c, sel_r}, 3'b000);
        btnu = 1'b0;

        // Single operation with btnd held
        btnl = 1'b1; alu_op_in = 4'b0010;
        tick(10);
        a0 = acc_seen;
        btnd = 1'b1; tick(20); btnd = 1'b0; tick(15);
        check("single_acc_pulses", acc_seen - a0, 1);
        check("single_op_count", op_count, 8'd1);
        check("single_alu_op", alu_op, 4'b0010);

        // Selection changes while busy must not disturb the latched op
        alu_op_in = 4'b0010;
        btnd = 1'b1;
        wait_busy("selchg_busy_timeout");
        alu_op_in = 4'b0110;
        tick(1);
        check("selchg_alu_op_exec", alu_op, 4'b0010);
        tick(20); btnd = 1'b0; tick(15);
        check("selchg_alu_op_after", alu_op, 4'b0010);
        check("selchg_op_count", op_count, 8'd2);

        // Bounce on btnd
        tick(10);
        a0 = acc_seen; busy_seen = 1'b0;
        btnd = 1'b1; tick(1); btnd = 1'b0; tick(1); btnd = 1'b1; tick(1); btnd = 1'b0;
        tick(20);
`ifdef CALC_DEBOUNCE_EN
        check("bounce_acc_pulses", acc_seen - a0, 0);
        check("bounce_busy_seen", busy_seen, 1'b0);
`else
        check("bounce_acc_ge1", (acc_seen - a0) >= 1, 1'b1);
`endif

        // Reset mid-EXEC aborts with no write
        alu_op_in = 4'b0101;
        btnd = 1'b1;
        wait_busy("rst_busy_timeout");
        pulse_reset();
        a0 = acc_seen;
        tick(25);
        check("post_rst_no_acc", acc_seen - a0, 0);
        check("post_rst_op_count", op_count, '0);

        // Randomised presses, selects and decoder output
        for (int n = 0; n < 40; n++) begin
            int unsigned hold, gap;
            btnl = 1'($urandom); btnc = 1'($urandom); btnr = 1'($urandom);
            alu_op_in = 4'($urandom);
            hold = $urandom_range(1, 12);
            gap  = $urandom_range(1, 12);
            btnd = 1'b1;
            for (int i = 0; i < int'(hold); i++) begin
                if ($urandom_range(0, 3) == 0) alu_op_in = 4'($urandom);
                tick(1);
            end
            btnd = 1'b0;
            tick(gap);
        end
        tick(30);

        // Counter wrap after 256 writes
        pulse_reset();
        tick(10);
        a0 = acc_seen;
        for (int n = 0; n < 256; n++) begin
            alu_op_in = 4'($urandom);
            btnd = 1'b1; tick(DB + 4);
            btnd = 1'b0; tick(DB + 4);
        end
        tick(20);
        check("wrap_acc_pulses", acc_seen - a0, 256);
        check("wrap_op_count", op_count, '0);

        tick(10);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
